// File: rtl/llr_in_layer.sv
// Input framer for the min-sum decoder: saturates channel LLRs and packs N_V of them
// into a double-buffered frame presented on all_llrs until the decoder acknowledges it.
module llr_in_layer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned IN_WIDTH = 10,
    parameter int unsigned N_V      = 44
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_WIDTH-1:0] in_llr,
    input  logic                       in_last,
    output logic [WIDTH*N_V-1:0]       all_llrs,
    output logic                       data_ready,
    input  logic                       frame_ack,
    output logic                       frame_err
);

    localparam int unsigned IDXW = (N_V > 1) ? $clog2(N_V) : 1;
    localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_LO = -SAT_HI;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_V - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_shadow [N_V];
    logic [WIDTH*N_V-1:0] r_all_llrs;
    logic              r_data_ready;
    logic              r_frame_err;

    logic              w_accept;
    logic              w_slot_free;
    logic              w_idx_last;
    logic              w_err;
    logic              w_last_ok;
    logic [WIDTH-1:0]  w_sat;
    logic [WIDTH*N_V-1:0] w_frame;

    assign in_ready   = (r_state == FILL);
    assign all_llrs   = r_all_llrs;
    assign data_ready = r_data_ready;
    assign frame_err  = r_frame_err;

    assign w_accept    = in_valid && in_ready;
    assign w_slot_free = !r_data_ready || frame_ack;
    assign w_idx_last  = (r_idx == LAST_IDX);
    assign w_err       = w_accept && (in_last != w_idx_last);
    assign w_last_ok   = w_accept && in_last && w_idx_last;

    // Symmetric clip: the most negative code is never produced.
    always_comb begin
        if (in_llr > SAT_HI) begin
            w_sat = SAT_HI[WIDTH-1:0];
        end else if (in_llr < SAT_LO) begin
            w_sat = SAT_LO[WIDTH-1:0];
        end else begin
            w_sat = in_llr[WIDTH-1:0];
        end
    end

    // In FILL the last slot bypasses the shadow so a free slot loads on the same edge.
    always_comb begin
        for (int unsigned i = 0; i < N_V; i++) begin
            w_frame[WIDTH*i +: WIDTH] = r_shadow[i];
        end
        if (r_state == FILL) begin
            w_frame[WIDTH*(N_V-1) +: WIDTH] = w_sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_all_llrs   <= '0;
            r_data_ready <= 1'b0;
            r_frame_err  <= 1'b0;
            for (int unsigned i = 0; i < N_V; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_frame_err <= w_err;
            case (r_state)
                FILL: begin
                    if (w_last_ok && w_slot_free) begin
                        r_all_llrs   <= w_frame;
                        r_data_ready <= 1'b1;
                        r_idx        <= '0;
                    end else begin
                        if (frame_ack) begin
                            r_data_ready <= 1'b0;
                        end
                        if (w_err) begin
                            r_idx <= '0;
                        end else if (w_last_ok) begin
                            r_shadow[r_idx] <= w_sat;
                            r_state         <= FULL;
                        end else if (w_accept) begin
                            r_shadow[r_idx] <= w_sat;
                            r_idx           <= r_idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (w_slot_free) begin
                        r_all_llrs   <= w_frame;
                        r_data_ready <= 1'b1;
                        r_idx        <= '0;
                        r_state      <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_llr_in_layer.sv
// Self-checking bench for llr_in_layer: saturation table, scoreboard of expected frames,
// and hand sequences for back-pressure, framing errors and reset.
module tb_llr_in_layer;

    localparam int W  = 8;
    localparam int IW = 10;
    localparam int NV = 44;
    localparam int NT = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [IW-1:0] in_llr = '0;
    logic                 in_last = 1'b0;
    logic [W*NV-1:0]      all_llrs;
    logic                 data_ready;
    logic                 frame_ack = 1'b0;
    logic                 frame_err;

    typedef struct {
        logic signed [IW-1:0] din;
        logic signed [W-1:0]  dexp;
    } sat_vec_t;

    sat_vec_t             tbl [NT];
    logic signed [IW-1:0] frame_in [NV];
    logic [W*NV-1:0]      exp_q [$];
    logic [W*NV-1:0]      cur_frame = '0;
    int                   checks = 0;
    int                   errors = 0;

    llr_in_layer #(.WIDTH(W), .IN_WIDTH(IW), .N_V(NV)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_llr    (in_llr),
        .in_last   (in_last),
        .all_llrs  (all_llrs),
        .data_ready(data_ready),
        .frame_ack (frame_ack),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [W-1:0] sat_model(input logic signed [IW-1:0] v);
        int x;
        logic [W-1:0] r;
        x = v;
        if (x > 127) x = 127;
        if (x < -127) x = -127;
        r = W'(x);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_model();
        logic [W*NV-1:0] f;
        for (int k = 0; k < NV; k++) f[W*k +: W] = sat_model(frame_in[k]);
        exp_q.push_back(f);
    endtask

    task automatic chk_frame(input string nm);
        logic [W*NV-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %0h", nm, all_llrs);
        end else begin
            e = exp_q.pop_front();
            cur_frame = e;
            if (all_llrs !== e) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", nm, all_llrs, e);
            end
        end
    endtask

    task automatic chk_held(input string nm);
        checks++;
        if (all_llrs !== cur_frame) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, all_llrs, cur_frame);
        end
    endtask

    task automatic send(input int from, input int upto, input int last_at, input bit chk_rdy);
        for (int k = from; k < upto; k++) begin
            if (chk_rdy) chk("in_ready_during_fill", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_llr   = frame_in[k];
            in_last  = (k == last_at);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{ 10'sd300,  8'sd127};
        tbl[1]  = '{-10'sd300, -8'sd127};
        tbl[2]  = '{-10'sd128, -8'sd127};
        tbl[3]  = '{ 10'sd127,  8'sd127};
        tbl[4]  = '{-10'sd127, -8'sd127};
        tbl[5]  = '{ 10'sd0,    8'sd0};
        tbl[6]  = '{-10'sd1,   -8'sd1};
        tbl[7]  = '{ 10'sd511,  8'sd127};
        tbl[8]  = '{-10'sd512, -8'sd127};
        tbl[9]  = '{ 10'sd128,  8'sd127};
        tbl[10] = '{-10'sd129, -8'sd127};
        tbl[11] = '{ 10'sd5,    8'sd5};

        // Reset values
        #3;
        chk("reset_data_ready", 64'(data_ready), 64'd0);
        chk("reset_frame_err", 64'(frame_err), 64'd0);
        chk("reset_all_llrs", 64'(all_llrs != '0), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Frame A: i-20, free slot
        for (int i = 0; i < NV; i++) frame_in[i] = IW'(i - 20);
        push_model();
        send(0, NV - 1, NV - 1, 1'b1);
        chk("a_data_ready_before_last", 64'(data_ready), 64'd0);
        send(NV - 1, NV, NV - 1, 1'b1);
        chk("a_data_ready", 64'(data_ready), 64'd1);
        chk("a_in_ready", 64'(in_ready), 64'd1);
        chk("a_slot0", 64'(all_llrs[0 +: W]), 64'(8'hEC));
        chk_frame("a_frame");

        // Ack with no pending frame
        ack();
        chk("noframe_ack_data_ready", 64'(data_ready), 64'd0);
        chk_held("noframe_ack_held");

        // Frame B: saturation table
        begin
            logic [W*NV-1:0] f;
            for (int k = 0; k < NV; k++) begin
                frame_in[k]   = tbl[k % NT].din;
                f[W*k +: W]   = tbl[k % NT].dexp;
            end
            exp_q.push_back(f);
        end
        send(0, NV, NV - 1, 1'b1);
        chk("b_data_ready", 64'(data_ready), 64'd1);
        for (int i = 0; i < NT; i++) begin
            logic [W-1:0] e;
            e = tbl[i].dexp;
            chk($sformatf("sat_slot%0d", i), 64'(all_llrs[W*i +: W]), 64'(e));
        end
        chk_frame("b_frame");

        // Frame C while B unacked
        for (int i = 0; i < NV; i++) frame_in[i] = IW'((i * 7) % 200 - 100);
        push_model();
        send(0, NV, NV - 1, 1'b1);
        chk("c_in_ready_full", 64'(in_ready), 64'd0);
        chk("c_data_ready_full", 64'(data_ready), 64'd1);
        chk_held("c_b_held");
        tick();
        tick();
        chk("c_in_ready_still_full", 64'(in_ready), 64'd0);
        chk_held("c_b_still_held");
        ack();
        chk("c_data_ready_no_gap", 64'(data_ready), 64'd1);
        chk("c_in_ready_back", 64'(in_ready), 64'd1);
        chk_frame("c_frame");

        // Frame D: ack coincides with last beat
        for (int i = 0; i < NV; i++) frame_in[i] = IW'((i * 11) % 250 - 125);
        push_model();
        send(0, NV - 1, NV - 1, 1'b1);
        in_valid  = 1'b1;
        in_llr    = frame_in[NV - 1];
        in_last   = 1'b1;
        frame_ack = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        frame_ack = 1'b0;
        chk("d_data_ready", 64'(data_ready), 64'd1);
        chk("d_in_ready", 64'(in_ready), 64'd1);
        chk_frame("d_frame");

        // Framing error: early last on beat 10
        for (int i = 0; i < NV; i++) frame_in[i] = IW'(i + 3);
        send(0, 11, 10, 1'b0);
        chk("err_early_pulse", 64'(frame_err), 64'd1);
        chk_held("err_early_held");
        tick();
        chk("err_early_pulse_end", 64'(frame_err), 64'd0);
        chk("err_early_data_ready", 64'(data_ready), 64'd1);

        // Framing error: 44th beat without last
        send(0, NV, -1, 1'b0);
        chk("err_nolast_pulse", 64'(frame_err), 64'd1);
        chk("err_nolast_in_ready", 64'(in_ready), 64'd1);
        chk_held("err_nolast_held");

        // Back-to-back errors
        in_valid = 1'b1;
        in_llr   = 10'sd1;
        in_last  = 1'b1;
        tick();
        chk("err_b2b_first", 64'(frame_err), 64'd1);
        tick();
        chk("err_b2b_second", 64'(frame_err), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("err_b2b_end", 64'(frame_err), 64'd0);

        // Clean frame E after errors
        ack();
        chk("e_pre_data_ready", 64'(data_ready), 64'd0);
        for (int i = 0; i < NV; i++) frame_in[i] = IW'(50 - i);
        push_model();
        send(0, NV, NV - 1, 1'b1);
        chk("e_data_ready", 64'(data_ready), 64'd1);
        chk_frame("e_frame");

        // Reset mid-frame (beat 20)
        for (int i = 0; i < NV; i++) frame_in[i] = IW'(i * 2 - 40);
        send(0, 20, -1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_data_ready", 64'(data_ready), 64'd0);
        chk("rst_mid_all_llrs", 64'(all_llrs != '0), 64'd0);
        chk("rst_mid_frame_err", 64'(frame_err), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst = 1'b1;
        push_model();
        send(0, NV, NV - 1, 1'b1);
        chk("f_frame_err", 64'(frame_err), 64'd0);
        chk("f_data_ready", 64'(data_ready), 64'd1);
        chk_frame("f_frame");

        // Reset while FULL
        for (int i = 0; i < NV; i++) frame_in[i] = IW'(-i);
        send(0, NV, NV - 1, 1'b1);
        chk("g_in_ready_full", 64'(in_ready), 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("rst_full_in_ready", 64'(in_ready), 64'd1);
        chk("rst_full_data_ready", 64'(data_ready), 64'd0);
        chk("rst_full_all_llrs", 64'(all_llrs != '0), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_full_no_reload", 64'(data_ready), 64'd0);
        for (int i = 0; i < NV; i++) frame_in[i] = IW'(i + 60);
        push_model();
        send(0, NV, NV - 1, 1'b1);
        chk("h_data_ready", 64'(data_ready), 64'd1);
        chk_frame("h_frame");

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/llr_in_layer.md
# llr_in_layer

Input-side framer for the neural min-sum decoder. Accepts channel LLRs one per beat over a valid/ready stream. Saturates each LLR to the decoder's symmetric WIDTH-bit range and assembles N_V of them into a packed, double-buffered frame. It presents the frame to the decoder layers as `all_llrs` with a `data_ready` level, holding it until the decoder acknowledges, while the next frame fills the shadow buffer behind it.

## Interface
- `WIDTH`, 8: decoder LLR width, signed two's complement.
- `IN_WIDTH`, 10: incoming channel LLR width, signed; must be >= WIDTH.
- `N_V`, 44: variable nodes, i.e. LLRs per frame.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_llr`/`in_last` valid this cycle.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_llr` in IN_WIDTH: signed channel LLR.
- `in_last` in 1: marks the final beat of a frame.
- `all_llrs` out WIDTH*N_V: frame presented to the decoder; LLR i occupies bits [WIDTH*i +: WIDTH].
- `data_ready` out 1: `all_llrs` holds a valid frame.
- `frame_ack` in 1: decoder has consumed the presented frame.
- `frame_err` out 1: one-cycle pulse when a framing error causes a frame to be discarded.

## Operation
- A beat is accepted when `in_valid && in_ready`.
  - Beat k of a frame (k = 0..N_V-1) writes LLR k into the shadow buffer.
  - The index counter is ceil(log2(N_V)) bits wide.
- Saturation: the result is `in_llr` clipped to [-(2^(WIDTH-1)-1), +(2^(WIDTH-1)-1)].
  - The range is symmetric, so -2^(WIDTH-1) never appears on `all_llrs`.
  - Clipping applies even when IN_WIDTH == WIDTH (-128 becomes -127 for WIDTH=8).
- Output slot is "free" in a cycle when `data_ready == 0 || frame_ack == 1`.
- `frame_ack` while `data_ready == 0` is ignored.
- Two states:
  - FILL: `in_ready = 1`.
  - FULL: shadow complete, `in_ready = 0`.
- Last beat accepted (k = N_V-1 with `in_last = 1`):
  - If the output slot is free that cycle: the shadow buffer plus the saturated last LLR load directly into `all_llrs`, `data_ready` is set to 1, the counter is cleared, and the state stays FILL.
  - Otherwise: the last LLR is written to the shadow buffer and the state goes to FULL.
- In FULL, on the first cycle the slot is free:
  - The shadow buffer is copied to `all_llrs` and `data_ready` stays or becomes 1.
  - The counter is cleared and the state returns to FILL.
- `frame_ack` with no complete shadow frame (in FILL, or on an edge that is not loading a frame) clears `data_ready` to 0.
- Framing error: an accepted beat with `in_last = 1` at k < N_V-1, or `in_last = 0` at k = N_V-1.
  - The partial frame is discarded and the counter is cleared.
  - `frame_err` pulses high on the following cycle.
  - `all_llrs` and `data_ready` are unaffected.
  - The erroneous beat itself is dropped.
- `all_llrs` changes only when a frame is loaded. It is never partially updated.

## Timing
- Reset values:
  - `all_llrs` = 0, `data_ready` = 0, `frame_err` = 0.
  - Counter = 0, state FILL, `in_ready` = 1 from the first cycle after reset deassertion.
- Reset mid-frame or while FULL drops all buffered data; no `frame_err` is generated.
- `in_ready` is registered-state derived: it is 0 exactly while FULL. It never depends combinationally on `in_valid`.
- Latency with a free slot: `data_ready` and the new `all_llrs` are visible the cycle after the last beat is accepted.
- Latency when FULL: the new frame is visible the cycle after the edge on which `frame_ack = 1`. `data_ready` stays high with no gap.
  - `in_ready` returns to 1 on that same cycle.
- Sustained throughput: one LLR per cycle, provided the decoder acks within N_V cycles of each `data_ready` frame.
- `frame_err` is a single-cycle pulse. Back-to-back errors give back-to-back pulses.

## Test plan
- Reset, then feed 44 beats of `in_llr` = i-20 with no gaps and `in_last` on beat 43:
  - `data_ready` rises 1 cycle after beat 43.
  - Slot i holds i-20.
  - `in_ready` stays 1 throughout.
- Saturation: feed beats of +300, -300, -128, +127, -127:
  - Slots read +127, -127, -127, +127, -127.
- Second frame while the first is unacked:
  - After 44 beats, `in_ready` = 0 and `all_llrs` still holds frame 1.
  - Pulse `frame_ack`: frame 2 appears next cycle, `data_ready` stays 1 and `in_ready` = 1.
- `frame_ack` with no pending frame:
  - `data_ready` falls to 0 next cycle and `all_llrs` is held.
- Framing errors:
  - `in_last` on beat 10 gives a `frame_err` pulse, and `all_llrs` is unchanged.
  - A 44th beat without `in_last` gives a `frame_err` pulse.
  - A following clean frame loads correctly.
- Assert `rst` = 0 mid-frame (beat 20) and while FULL:
  - All outputs go to reset values immediately.
  - A new 44-beat frame loads from index 0.
